// File: rtl/arp_tx_if.sv
// Byte-wide AXI-Stream link from the ARP reply generator to the Ethernet MAC.
// A byte transfers on a rising clock edge where tvalid && tready are both high. Once tvalid
// is raised, it and tdata/tlast stay unchanged until that transfer completes.
interface arp_tx_if;
  logic [7:0] tx_axis_mac_tdata;
  logic       tx_axis_mac_tvalid;
  logic       tx_axis_mac_tlast;
  logic       tx_axis_mac_tready;

  modport master (
    output tx_axis_mac_tdata,
    output tx_axis_mac_tvalid,
    output tx_axis_mac_tlast,
    input  tx_axis_mac_tready
  );

  modport slave (
    input  tx_axis_mac_tdata,
    input  tx_axis_mac_tvalid,
    input  tx_axis_mac_tlast,
    output tx_axis_mac_tready
  );
endinterface

// File: rtl/arp_tx.sv
// ARP reply generator: on each request, streams a 60-byte Ethernet/ARP reply frame (no FCS)
// over AXI-Stream, with a one-deep pending slot for requests that arrive while a frame is in flight.
module arp_tx #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_01
) (
  input  logic        tx_mac_aclk,
  input  logic        tx_mac_resetn,
  input  logic        tx_arp_req,
  input  logic [47:0] tx_arp_dmac,
  input  logic [31:0] tx_arp_dip,
  output logic        tx_arp_busy,
  arp_tx_if.master    axis,
  output logic [1:0]  dbg_state_o,
  output logic [5:0]  dbg_byte_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [5:0] LAST_BYTE = 6'd59;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [47:0] act_dmac_q, act_dmac_d;
  logic [31:0] act_dip_q, act_dip_d;
  logic        pend_q, pend_d;
  logic [47:0] pend_dmac_q, pend_dmac_d;
  logic [31:0] pend_dip_q, pend_dip_d;

  logic       hs;
  logic       last_byte;
  logic [7:0] byte_val;

  assign hs        = (state_q == SEND) && axis.tx_axis_mac_tready;
  assign last_byte = (cnt_q == LAST_BYTE);

  // Byte sel (0 = most significant) of a 48-bit MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] v, input logic [5:0] sel);
    logic [47:0] sh;
    sh = v << {sel, 3'b000};
    return sh[47:40];
  endfunction

  // Byte sel (0 = most significant) of a 32-bit IP address.
  function automatic logic [7:0] ip_byte(input logic [31:0] v, input logic [5:0] sel);
    logic [31:0] sh;
    sh = v << {sel, 3'b000};
    return sh[31:24];
  endfunction

  always_comb begin
    byte_val = 8'h00;
    if (cnt_q < 6'd6) begin
      byte_val = mac_byte(act_dmac_q, cnt_q);
    end else if (cnt_q < 6'd12) begin
      byte_val = mac_byte(LOCAL_MAC, cnt_q - 6'd6);
    end else if (cnt_q < 6'd22) begin
      // Ethertype, htype, ptype, hlen, plen and opcode (reply).
      case (cnt_q)
        6'd12:   byte_val = 8'h08;
        6'd13:   byte_val = 8'h06;
        6'd14:   byte_val = 8'h00;
        6'd15:   byte_val = 8'h01;
        6'd16:   byte_val = 8'h08;
        6'd17:   byte_val = 8'h00;
        6'd18:   byte_val = 8'h06;
        6'd19:   byte_val = 8'h04;
        6'd20:   byte_val = 8'h00;
        6'd21:   byte_val = 8'h02;
        default: byte_val = 8'h00;
      endcase
    end else if (cnt_q < 6'd28) begin
      byte_val = mac_byte(LOCAL_MAC, cnt_q - 6'd22);
    end else if (cnt_q < 6'd32) begin
      byte_val = ip_byte(LOCAL_IP, cnt_q - 6'd28);
    end else if (cnt_q < 6'd38) begin
      byte_val = mac_byte(act_dmac_q, cnt_q - 6'd32);
    end else if (cnt_q < 6'd42) begin
      byte_val = ip_byte(act_dip_q, cnt_q - 6'd38);
    end else begin
      byte_val = 8'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_dmac_d  = act_dmac_q;
    act_dip_d   = act_dip_q;
    pend_d      = pend_q;
    pend_dmac_d = pend_dmac_q;
    pend_dip_d  = pend_dip_q;

    case (state_q)
      IDLE: begin
        if (tx_arp_req) begin
          act_dmac_d = tx_arp_dmac;
          act_dip_d  = tx_arp_dip;
          cnt_d      = 6'd0;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (hs) begin
          if (last_byte) begin
            cnt_d   = 6'd0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        if (tx_arp_req) begin
          pend_d      = 1'b1;
          pend_dmac_d = tx_arp_dmac;
          pend_dip_d  = tx_arp_dip;
        end
      end

      GAP: begin
        // A request arriving in the exit cycle is newer than any pending one, so it wins.
        if (tx_arp_req) begin
          act_dmac_d = tx_arp_dmac;
          act_dip_d  = tx_arp_dip;
          pend_d     = 1'b0;
          state_d    = SEND;
        end else if (pend_q) begin
          act_dmac_d = pend_dmac_q;
          act_dip_d  = pend_dip_q;
          pend_d     = 1'b0;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
        cnt_d = 6'd0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      act_dmac_q  <= 48'd0;
      act_dip_q   <= 32'd0;
      pend_q      <= 1'b0;
      pend_dmac_q <= 48'd0;
      pend_dip_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_dmac_q  <= act_dmac_d;
      act_dip_q   <= act_dip_d;
      pend_q      <= pend_d;
      pend_dmac_q <= pend_dmac_d;
      pend_dip_q  <= pend_dip_d;
    end
  end

  // Outputs decode registered state only, so a reset drops them at once and they hold during stalls.
  assign axis.tx_axis_mac_tvalid = (state_q == SEND);
  assign axis.tx_axis_mac_tlast  = (state_q == SEND) && last_byte;
  assign axis.tx_axis_mac_tdata  = (state_q == SEND) ? byte_val : 8'h00;

  assign tx_arp_busy    = (state_q != IDLE) || pend_q;
  assign dbg_state_o    = state_q;
  assign dbg_byte_cnt_o = cnt_q;

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: byte-level scoreboard against hand-built frames,
// plus stall, pending-request, gap and reset-abort scenarios.
module tb_arp_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [47:0] dmac = 48'd0;
  logic [31:0] dip = 32'd0;
  logic        tready = 1'b1;
  logic        rand_mode = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [5:0]  dbg_cnt;

  always #5 clk = ~clk;

  arp_tx_if axis ();
  assign axis.tx_axis_mac_tready = tready;

  arp_tx dut (
    .tx_mac_aclk    (clk),
    .tx_mac_resetn  (rst_n),
    .tx_arp_req     (req),
    .tx_arp_dmac    (dmac),
    .tx_arp_dip     (dip),
    .tx_arp_busy    (busy),
    .axis           (axis),
    .dbg_state_o    (dbg_state),
    .dbg_byte_cnt_o (dbg_cnt)
  );

  localparam logic [47:0] MAC_A = 48'h11_22_33_44_55_66;
  localparam logic [31:0] IP_A  = 32'hC0_A8_01_64;
  localparam logic [47:0] MAC_B = 48'hAA_AA_AA_AA_AA_AA;
  localparam logic [31:0] IP_B  = 32'hC0_A8_01_02;
  localparam logic [47:0] MAC_C = 48'h02_00_00_00_00_0C;
  localparam logic [31:0] IP_C  = 32'h0A_00_00_0C;
  localparam logic [47:0] MAC_D = 48'h02_00_00_00_00_0D;
  localparam logic [31:0] IP_D  = 32'h0A_00_00_0D;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  int   mon_idx = 0;
  int   frames = 0;
  logic in_gap = 1'b0;
  int   gap_len = 0;
  int   last_gap = -1;
  logic stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame built byte by byte from the field layout.
  task automatic push_frame(input logic [47:0] m, input logic [31:0] ip);
    logic [47:0] lmac;
    logic [31:0] lip;
    logic [7:0]  hdr [10];
    lmac = 48'h00_0A_35_01_FE_C0;
    lip  = 32'hC0_A8_01_01;
    hdr  = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int i = 0; i < 6; i++)  exp_q.push_back(m[47-8*i -: 8]);
    for (int i = 0; i < 6; i++)  exp_q.push_back(lmac[47-8*i -: 8]);
    for (int i = 0; i < 10; i++) exp_q.push_back(hdr[i]);
    for (int i = 0; i < 6; i++)  exp_q.push_back(lmac[47-8*i -: 8]);
    for (int i = 0; i < 4; i++)  exp_q.push_back(lip[31-8*i -: 8]);
    for (int i = 0; i < 6; i++)  exp_q.push_back(m[47-8*i -: 8]);
    for (int i = 0; i < 4; i++)  exp_q.push_back(ip[31-8*i -: 8]);
    for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic pulse(input logic [47:0] m, input logic [31:0] ip);
    dmac = m;
    dip  = ip;
    req  = 1'b1;
    @(posedge clk);
    #1;
    req  = 1'b0;
  endtask

  task automatic wait_idx(input int idx);
    int n;
    n = 0;
    while (mon_idx != idx && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idx_timeout", n < 2000, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  task automatic wait_gap();
    int n;
    n = 0;
    while (dbg_state != 2'd2 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_gap_timeout", n < 2000, 1);
  endtask

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: samples at the falling edge, scores every accepted byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", axis.tx_axis_mac_tvalid, 1);
        check("stall_data", axis.tx_axis_mac_tdata, prev_data);
        check("stall_last", axis.tx_axis_mac_tlast, prev_last);
      end
      if (in_gap) begin
        if (!axis.tx_axis_mac_tvalid) gap_len++;
        else begin
          last_gap = gap_len;
          in_gap   = 1'b0;
        end
      end
      if (axis.tx_axis_mac_tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("byte", axis.tx_axis_mac_tdata, e);
        end
        check("tlast", axis.tx_axis_mac_tlast, mon_idx == 59);
        if (mon_idx == 59) begin
          mon_idx = 0;
          frames++;
          in_gap  = 1'b1;
          gap_len = 0;
        end else begin
          mon_idx++;
        end
      end
      stall_prev = axis.tx_axis_mac_tvalid && !tready;
      prev_data  = axis.tx_axis_mac_tdata;
      prev_last  = axis.tx_axis_mac_tlast;
    end else begin
      stall_prev = 1'b0;
      in_gap     = 1'b0;
    end
  end

  initial begin
    int f0;
    int seen;

    // Reset values, with a request held during reset that must be ignored.
    dmac = MAC_A;
    dip  = IP_A;
    req  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", axis.tx_axis_mac_tvalid, 0);
    check("rst_tlast", axis.tx_axis_mac_tlast, 0);
    check("rst_tdata", axis.tx_axis_mac_tdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_cnt", dbg_cnt, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_tvalid", axis.tx_axis_mac_tvalid, 0);

    // Single reply with tready held high; byte 0 one clock after the request.
    f0 = frames;
    push_frame(MAC_A, IP_A);
    pulse(MAC_A, IP_A);
    check("lat_tvalid", axis.tx_axis_mac_tvalid, 1);
    check("lat_tdata", axis.tx_axis_mac_tdata, 8'h11);
    check("lat_busy", busy, 1);
    wait_done("drain_basic", 200);
    check("frames_basic", frames - f0, 1);

    // Same frame under 50% random backpressure.
    f0 = frames;
    rand_mode = 1'b1;
    push_frame(MAC_A, IP_A);
    pulse(MAC_A, IP_A);
    wait_done("drain_random", 2000);
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    tready = 1'b1;
    check("frames_random", frames - f0, 1);

    // Second request at byte 20 is served after exactly one gap cycle.
    f0 = frames;
    push_frame(MAC_A, IP_A);
    push_frame(MAC_B, IP_B);
    pulse(MAC_A, IP_A);
    wait_idx(20);
    pulse(MAC_B, IP_B);
    wait_done("drain_pending", 400);
    check("frames_pending", frames - f0, 2);
    check("gap_len", last_gap, 1);

    // Three requests during one frame: only the first and the last are served.
    f0 = frames;
    push_frame(MAC_A, IP_A);
    push_frame(MAC_D, IP_D);
    pulse(MAC_A, IP_A);
    wait_idx(5);
    pulse(MAC_B, IP_B);
    wait_idx(20);
    pulse(MAC_C, IP_C);
    wait_idx(40);
    pulse(MAC_D, IP_D);
    wait_done("drain_three", 400);
    check("frames_three", frames - f0, 2);

    // Request arriving in the GAP cycle overrides the pending one.
    f0 = frames;
    push_frame(MAC_A, IP_A);
    push_frame(MAC_C, IP_C);
    pulse(MAC_A, IP_A);
    wait_idx(10);
    pulse(MAC_B, IP_B);
    wait_gap();
    pulse(MAC_C, IP_C);
    wait_done("drain_gapreq", 400);
    check("frames_gapreq", frames - f0, 2);

    // Reset in the middle of a frame aborts it; nothing resumes afterwards.
    push_frame(MAC_A, IP_A);
    pulse(MAC_A, IP_A);
    wait_idx(30);
    check("pre_abort_cnt", dbg_cnt, 6'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tvalid", axis.tx_axis_mac_tvalid, 0);
    check("abort_tlast", axis.tx_axis_mac_tlast, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    mon_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (axis.tx_axis_mac_tvalid || busy) seen++;
    end
    check("no_resume", seen, 0);
    f0 = frames;
    push_frame(MAC_A, IP_A);
    pulse(MAC_A, IP_A);
    wait_done("drain_after_abort", 200);
    check("frames_after_abort", frames - f0, 1);

    // tready held low for 100 cycles: byte 0 held, counter stays at 0.
    f0 = frames;
    tready = 1'b0;
    push_frame(MAC_A, IP_A);
    pulse(MAC_A, IP_A);
    repeat (100) @(posedge clk);
    #1;
    check("hold_tvalid", axis.tx_axis_mac_tvalid, 1);
    check("hold_tdata", axis.tx_axis_mac_tdata, 8'h11);
    check("hold_cnt", dbg_cnt, 6'd0);
    check("hold_busy", busy, 1);
    tready = 1'b1;
    wait_done("drain_hold", 200);
    check("frames_hold", frames - f0, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arp_tx.md
ARP_TX -- requirements
Module: arp_tx

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h00_0A_35_01_FE_C0, the local MAC address placed in the Ethernet source and ARP sender-hardware fields.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0_A8_01_01 (192.168.1.1), the local IP placed in the ARP sender-protocol field.
REQ-003 SHALL use one clock and one reset: tx_mac_aclk  input  1  the single clock for all logic; tx_mac_resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_arp_req  input  1  one-cycle pulse requesting one ARP reply.
REQ-005 SHALL have port tx_arp_dmac  input  48  requester MAC address, sampled with tx_arp_req.
REQ-006 SHALL have port tx_arp_dip  input  32  requester IP address, sampled with tx_arp_req.
REQ-007 SHALL have port tx_axis_mac_tdata  output  8  frame byte.
REQ-008 SHALL have port tx_axis_mac_tvalid  output  1  byte valid.
REQ-009 SHALL have port tx_axis_mac_tlast  output  1  last byte of frame (byte 59).
REQ-010 SHALL have port tx_axis_mac_tready  input  1  downstream MAC accepts byte.
REQ-011 SHALL have port tx_arp_busy  output  1  high while a frame is in IDLE-excluded states or a request is pending.

Function
REQ-012 SHALL emit a 60-byte frame, no FCS (MAC appends it), MSB-first per field: bytes 0-5 tx_arp_dmac; 6-11 LOCAL_MAC; 12-13 0x0806; 14-15 0x0001; 16-17 0x0800; 18 0x06; 19 0x04; 20-21 0x0002; 22-27 LOCAL_MAC; 28-31 LOCAL_IP; 32-37 tx_arp_dmac; 38-41 tx_arp_dip; 42-59 0x00.
REQ-013 SHALL use a 6-bit byte counter, 0..59, incremented only on tvalid && tready, cleared to 0 on the byte-59 handshake.
REQ-014 SHALL hold tdata, tvalid, tlast stable while tvalid && !tready.
REQ-015 SHALL assert tlast only with tvalid at byte 59.
REQ-016 SHALL implement states IDLE, SEND, GAP.
REQ-017 IDLE: on tx_arp_req, latch dmac/dip into the active registers and go to SEND; tvalid rises the next cycle with byte 0 (latency 1 clock).
REQ-018 SEND: tvalid high; on the byte-59 handshake go to GAP.
REQ-019 GAP: tvalid low for exactly one cycle; then SEND if a request is pending (pending copied to active registers, flag cleared), else IDLE.
REQ-020 SHALL capture tx_arp_req arriving in SEND or GAP into a one-deep pending buffer (dmac, dip, flag); a newer request overwrites older pending contents; active-frame fields SHALL NOT change mid-frame.
REQ-021 A request in the same cycle GAP exits SHALL be taken as pending and served next, overwriting any prior pending entry.
REQ-022 tx_arp_busy SHALL be high in SEND and GAP or when the pending flag is set; low otherwise.
REQ-023 tready low for any number of cycles SHALL stall the frame without byte loss or duplication.

Reset
REQ-024 While tx_mac_resetn is low: state IDLE, byte counter 0, pending flag 0, tvalid 0, tlast 0, tdata 0x00, tx_arp_busy 0, latched addresses 0.
REQ-025 Reset asserted mid-frame SHALL abort immediately (tvalid/tlast low asynchronously); no resumption after release.
REQ-026 tx_arp_req coincident with reset release edge cycle while reset low SHALL be ignored.

Verification
REQ-027 tready=1, pulse req with dmac=48'h11_22_33_44_55_66, dip=32'hC0_A8_01_64 -> 60 bytes from next cycle: 11 22 33 44 55 66 00 0A 35 01 FE C0 08 06 00 01 08 00 06 04 00 02 00 0A 35 01 FE C0 C0 A8 01 01 11 22 33 44 55 66 C0 A8 01 64, then 18x 00; tlast on byte 59 only.
REQ-028 tready toggled pseudo-randomly (50%) -> byte stream identical to REQ-027; tdata constant during every stall.
REQ-029 Second req (dmac=AA..AA, dip=C0A80102) at byte 20 of first frame -> first frame unchanged, one tvalid-low GAP cycle, second frame with AA..AA/C0A80102.
REQ-030 Three reqs during one frame -> only first and last served; exactly two frames emitted.
REQ-031 Reset low at byte 30 -> tvalid 0, busy 0 immediately; after release, no output until new req, which produces a full frame starting at byte 0.
REQ-032 tready=0 held 100 cycles after req -> tvalid stays 1 with byte 0 (tdata=0x11), counter 0, busy 1.
